md_seq: RTL and testbench
=========================

MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL provide ports, upstream side: ex_valid  in  1  EX holds an M-extension instr; ex_op  in  md_op_e  operation; ex_rs1  in  32  operand a; ex_rs2  in  32  operand b; ex_rd  in  5  destination; flush  in  1  kill current/in-flight M instr.
REQ-003 SHALL provide ports, muldiv side: md_start  out  1; md_op  out  md_op_e; md_a  out  32; md_b  out  32; md_result  in  32; md_busy  in  1; md_valid  in  1.
REQ-004 SHALL provide ports, pipeline side: stall_req  out  1  hold IF/ID/EX; wb_valid  out  1  writeback pulse; wb_rd  out  5; wb_data  out  32.

Function
REQ-005 SHALL implement FSM states IDLE, DIV_WAIT, DRAIN.
REQ-006 md_op/md_a/md_b SHALL be driven combinationally from ex_op/ex_rs1/ex_rs2 in IDLE.
REQ-007 IDLE, ex_valid, MUL/MULH/MULHSU/MULHU, !flush: md_start=1; md_valid is expected the same cycle; stall_req=0; state stays IDLE.
REQ-008 Every accepted completion (MUL, DIV_WAIT md_valid, or bypass) SHALL register md_result (or the bypass value) into wb_data and rd into wb_rd, and assert wb_valid for exactly one cycle, on the following cycle.
REQ-009 IDLE, ex_valid, DIV/DIVU/REM/REMU, !flush: md_start=1 for one cycle, latch ex_rd, stall_req=1, next state DIV_WAIT.
REQ-010 DIV_WAIT: md_start=0 (no reissue while EX is held); stall_req=1 until the cycle md_valid=1, in which stall_req=0, then IDLE.
REQ-011 flush in IDLE SHALL suppress md_start, stall_req, and writeback for that cycle.
REQ-012 flush in DIV_WAIT without md_valid: stall_req=0, next DRAIN; the divider is not aborted.
REQ-013 flush coincident with md_valid in DIV_WAIT: result discarded (no wb_valid), next IDLE.
REQ-014 DRAIN: md_start=0; stall_req = ex_valid (any M op waits); on md_valid discard the result, next IDLE; issue resumes from IDLE the cycle after.
REQ-015 md_valid in IDLE without md_start, or in DRAIN, SHALL never produce wb_valid.
REQ-016 At most one instruction SHALL be in flight; md_start SHALL never assert while md_busy=1.

Reset
REQ-017 rst_n=0 at a clock edge SHALL force IDLE and drive stall_req, md_start, and wb_valid to 0, and wb_rd and wb_data to 0, including mid-division.
REQ-018 muldiv SHALL share the same rst_n, so the divider is cleared by the same reset; no stale md_valid is consumed after reset.

Configuration
REQ-019 Macro MD_SEQ_DIV_BYPASS_EN, when defined, SHALL complete special divides in IDLE like a MUL (no md_start, stall_req=0, wb next cycle).
- Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
- DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
REQ-020 Without MD_SEQ_DIV_BYPASS_EN, all divides SHALL go through muldiv per REQ-009/010, and no bypass logic SHALL be synthesised.

Verification
REQ-021 MUL rs1=7, rs2=-3, rd=5 -> md_start same cycle, stall_req=0, next cycle wb_valid=1, wb_rd=5, wb_data=0xFFFFFFEB.
REQ-022 DIVU rs1=100, rs2=7, rd=3 -> stall_req high from the issue cycle until the md_valid cycle, single md_start pulse, wb_data=14 one cycle after md_valid; REMU gives 2.
REQ-023 DIV 100/7 issued, flush 5 cycles later -> stall_req drops, state DRAIN, no wb_valid; a MUL presented during DRAIN stalls, then issues the cycle after IDLE and writes back correctly.
REQ-024 DIV -> flush coincident with md_valid -> no wb_valid; next DIV issues from IDLE.
REQ-025 Bypass build: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each one cycle later, md_start never asserted; non-bypass build: same results via muldiv with stall.
REQ-026 rst_n=0 mid-DIV_WAIT -> next cycle IDLE, all outputs 0; a fresh DIVU 9/3 then yields 3.

Source files
------------

// File: rtl/md_seq.sv
// -----------------------------------------------------------------------------
// md_seq -- sequencer between the EX stage and a shared multiply/divide unit.
//
// Multiplies issue and complete in one cycle: md_valid comes back in the
// issue cycle and the result is written back on the next cycle. Divides issue
// once, then hold the pipeline through DIV_WAIT until the divider answers. A
// flush during a divide moves the FSM to DRAIN. In DRAIN the divider runs to
// completion and its result is thrown away, so at most one operation is ever
// in flight.
//
// Optional feature (macro MD_SEQ_DIV_BYPASS_EN): divide-by-zero and signed
// overflow (0x80000000 / -1) are answered locally in IDLE. They complete like
// a multiply and never start the divider.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   ex_valid/ex_op       EX holds an M instruction / its operation
//   ex_rs1/ex_rs2/ex_rd  operands and destination register
//   flush                kill the current or in-flight M instruction
//   md_start/md_op       issue strobe and operation to muldiv
//   md_a/md_b            operands to muldiv
//   md_result/md_busy/md_valid  muldiv result, busy, result strobe
//   stall_req            hold IF/ID/EX
//   wb_valid/wb_rd/wb_data  one-cycle writeback pulse, register, data
//
// Op encoding (funct3): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                       4 DIV, 5 DIVU, 6 REM, 7 REMU
// -----------------------------------------------------------------------------
module md_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs1,
  input  logic [DATA_W-1:0] ex_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              md_start,
  output logic [2:0]        md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_busy,
  input  logic              md_valid,
  output logic              stall_req,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIV_WAIT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

`ifdef MD_SEQ_DIV_BYPASS_EN
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Signed ops are DIV/REM (op[0]=0); REM/REMU have op[1]=1.
  function automatic logic div_special(input logic [2:0] op,
                                       input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
    return (b == '0) || (!op[0] && (a == SMIN) && (b == -1));
  endfunction

  function automatic logic [DATA_W-1:0] div_special_val(
      input logic [2:0] op,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    else         return op[1] ? '0 : a;
  endfunction
`endif

  logic [1:0]        state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              is_div;

  // The operands go straight through. Outside IDLE they are ignored because
  // md_start stays low.
  assign md_op  = ex_op;
  assign md_a   = ex_rs1;
  assign md_b   = ex_rs2;
  assign is_div = ex_op[2];

  // ---- issue / completion decode ----
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    md_start   = 1'b0;
    stall_req  = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          if (md_busy) begin
            // Never start into a busy unit; hold EX until it frees up.
            stall_req = 1'b1;
          end else if (!is_div) begin
            md_start = 1'b1;
            if (md_valid) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
              wb_data_d  = md_result;
            end
          end
`ifdef MD_SEQ_DIV_BYPASS_EN
          else if (div_special(ex_op, ex_rs1, ex_rs2)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = div_special_val(ex_op, ex_rs1, ex_rs2);
          end
`endif
          else begin
            md_start  = 1'b1;
            stall_req = 1'b1;
            rd_d      = ex_rd;
            state_d   = DIV_WAIT;
          end
        end
      end
      DIV_WAIT: begin
        if (md_valid) begin
          state_d = IDLE;
          if (!flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = md_result;
          end
        end else if (flush) begin
          // The divider is left running. DRAIN swallows its result.
          state_d = DRAIN;
        end else begin
          stall_req = 1'b1;
        end
      end
      DRAIN: begin
        stall_req = ex_valid;
        if (md_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- state / writeback registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_md_seq.sv
// -----------------------------------------------------------------------------
// tb_md_seq -- directed bench for md_seq with a small muldiv model attached.
// The model answers multiplies in the issue cycle. It answers divides
// DIV_LAT-1 cycles after the issue edge and shares rst_n with the DUT.
// -----------------------------------------------------------------------------
module tb_md_seq;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_REM   = 3'd6;
  localparam logic [2:0] OP_REMU  = 3'd7;
  localparam int         DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = '0;
  logic [31:0] ex_rs1 = '0, ex_rs2 = '0;
  logic [4:0]  ex_rd = '0;
  logic        flush = 1'b0;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b, md_result;
  logic        md_busy, md_valid;
  logic        stall_req, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  md_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_result(md_result), .md_busy(md_busy), .md_valid(md_valid),
    .stall_req(stall_req), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // ---- muldiv model ----
  function automatic logic [31:0] mul_res(input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] pa, pb, p;
    logic sa, sb;
    sa = (op == 3'd1) || (op == 3'd2);
    sb = (op == 3'd1);
    pa = $signed({{34{sa & a[31]}}, a});
    pb = $signed({{34{sb & b[31]}}, b});
    p  = pa * pb;
    return (op == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_res(input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      3'd4:    return sa / sb;
      3'd5:    return a / b;
      3'd6:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  logic        div_busy;
  int          div_cnt;
  logic [2:0]  div_op;
  logic [31:0] div_a, div_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      div_cnt  <= 0;
      div_op   <= '0;
      div_a    <= '0;
      div_b    <= '0;
    end else if (md_start && md_op[2]) begin
      div_busy <= 1'b1;
      div_cnt  <= DIV_LAT;
      div_op   <= md_op;
      div_a    <= md_a;
      div_b    <= md_b;
    end else if (div_busy) begin
      if (div_cnt == 1) div_busy <= 1'b0;
      div_cnt <= div_cnt - 1;
    end
  end

  assign md_busy = div_busy;

  always_comb begin
    md_valid  = 1'b0;
    md_result = '0;
    if (div_busy && div_cnt == 1) begin
      md_valid  = 1'b1;
      md_result = div_res(div_op, div_a, div_b);
    end else if (md_start && !md_op[2]) begin
      md_valid  = 1'b1;
      md_result = mul_res(md_op, md_a, md_b);
    end
  end

  // ---- helpers ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    ex_valid = v;
    ex_op    = op;
    ex_rs1   = a;
    ex_rs2   = b;
    ex_rd    = rd;
  endtask

  // Issue a divide through muldiv, hold EX while stalled, check writeback.
  task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int  starts, drops;
    bit  seen;
    set_ex(1'b1, op, a, b, rd);
    #1;
    check({tag, "_start"}, {31'd0, md_start}, 32'd1);
    check({tag, "_stall_issue"}, {31'd0, stall_req}, 32'd1);
    starts = 1;
    drops  = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      starts += int'(md_start);
      if (md_valid) begin
        seen = 1'b1;
        check({tag, "_stall_at_valid"}, {31'd0, stall_req}, 32'd0);
        set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
      end else begin
        drops += int'(!stall_req);
      end
    end
    check({tag, "_md_valid_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_stall_drops"}, drops, 32'd0);
    check({tag, "_start_pulses"}, starts, 32'd1);
    tick();
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({tag, "_wb_data"}, wb_data, exp);
    tick();
    check({tag, "_wb_single"}, {31'd0, wb_valid}, 32'd0);
  endtask

`ifdef MD_SEQ_DIV_BYPASS_EN
  task automatic run_byp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    set_ex(1'b1, op, a, b, rd);
    #1;
    check({tag, "_no_start"}, {31'd0, md_start}, 32'd0);
    check({tag, "_no_stall"}, {31'd0, stall_req}, 32'd0);
    tick();
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({tag, "_wb_data"}, wb_data, exp);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  starts, wbs, lows;
    bit  seen;

    // Reset state
    tick();
    tick();
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_start", {31'd0, md_start}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // MUL 7 * -3 -> rd 5
    set_ex(1'b1, OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    #1;
    check("mul_start", {31'd0, md_start}, 32'd1);
    check("mul_stall", {31'd0, stall_req}, 32'd0);
    tick();
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check("mul_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mul_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("mul_wb_data", wb_data, 32'hFFFF_FFEB);
    tick();
    check("mul_wb_single", {31'd0, wb_valid}, 32'd0);

    // MULHU 0xFFFFFFFF * 2 -> high word 1
    set_ex(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd11);
    tick();
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check("mulhu_wb_data", wb_data, 32'd1);
    check("mulhu_wb_rd", {27'd0, wb_rd}, 32'd11);

    // Divides through muldiv
    run_div("divu", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14);
    run_div("remu", OP_REMU, 32'd100, 32'd7, 5'd3, 32'd2);

    // Special divides
`ifdef MD_SEQ_DIV_BYPASS_EN
    run_byp("div0", OP_DIV, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run_byp("rem0", OP_REM, 32'd5, 32'd0, 5'd13, 32'd5);
    run_byp("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
`else
    run_div("div0", OP_DIV, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run_div("rem0", OP_REM, 32'd5, 32'd0, 5'd13, 32'd5);
    run_div("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
`endif

    // Flush in IDLE suppresses everything
    set_ex(1'b1, OP_MUL, 32'd3, 32'd4, 5'd1);
    flush = 1'b1;
    #1;
    check("iflush_mul_start", {31'd0, md_start}, 32'd0);
    check("iflush_mul_stall", {31'd0, stall_req}, 32'd0);
    tick();
    set_ex(1'b1, OP_DIVU, 32'd8, 32'd2, 5'd1);
    #1;
    check("iflush_mul_wb", {31'd0, wb_valid}, 32'd0);
    check("iflush_div_start", {31'd0, md_start}, 32'd0);
    check("iflush_div_stall", {31'd0, stall_req}, 32'd0);
    tick();
    flush = 1'b0;
    set_ex(1'b1, OP_MUL, 32'd3, 32'd4, 5'd2);
    #1;
    check("iflush_div_wb", {31'd0, wb_valid}, 32'd0);
    check("iflush_then_mul_start", {31'd0, md_start}, 32'd1);
    tick();
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check("iflush_then_mul_data", wb_data, 32'd12);

    // DIV then flush 5 cycles later -> DRAIN; MUL waits, then issues
    set_ex(1'b1, OP_DIV, 32'd100, 32'd7, 5'd4);
    #1;
    check("drain_div_start", {31'd0, md_start}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    flush = 1'b1;
    #1;
    check("drain_flush_stall", {31'd0, stall_req}, 32'd0);
    tick();
    flush = 1'b0;
    set_ex(1'b1, OP_MUL, 32'd6, 32'd7, 5'd9);
    #1;
    check("drain_mul_stall", {31'd0, stall_req}, 32'd1);
    check("drain_mul_nostart", {31'd0, md_start}, 32'd0);
    seen = 1'b0;
    wbs = 0;
    starts = 0;
    lows = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (md_valid) begin
        seen = 1'b1;
      end else begin
        tick();
        wbs    += int'(wb_valid);
        starts += int'(md_start);
        lows   += int'(!stall_req);
      end
    end
    check("drain_valid_seen", {31'd0, seen}, 32'd1);
    check("drain_wb_count", wbs, 32'd0);
    check("drain_start_count", starts, 32'd0);
    check("drain_stall_lows", lows, 32'd0);
    check("drain_stall_at_valid", {31'd0, stall_req}, 32'd1);
    tick();
    check("drain_discard_wb", {31'd0, wb_valid}, 32'd0);
    check("drain_mul_issue", {31'd0, md_start}, 32'd1);
    check("drain_mul_nostall", {31'd0, stall_req}, 32'd0);
    tick();
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check("drain_mul_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("drain_mul_wb_rd", {27'd0, wb_rd}, 32'd9);
    check("drain_mul_wb_data", wb_data, 32'd42);

    // Flush coincident with md_valid -> discarded; next DIV from IDLE
    set_ex(1'b1, OP_DIV, 32'd50, 32'd5, 5'd6);
    tick();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (md_valid) seen = 1'b1;
      else tick();
    end
    check("cflush_valid_seen", {31'd0, seen}, 32'd1);
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    flush = 1'b1;
    #1;
    check("cflush_stall", {31'd0, stall_req}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("cflush_no_wb", {31'd0, wb_valid}, 32'd0);
    run_div("div_after", OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA);

    // Reset mid DIV_WAIT
    set_ex(1'b1, OP_DIVU, 32'd1000, 32'd7, 5'd8);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ex(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check("mrst_stall", {31'd0, stall_req}, 32'd0);
    check("mrst_start", {31'd0, md_start}, 32'd0);
    check("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mrst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("mrst_wb_data", wb_data, 32'd0);
    check("mrst_md_valid", {31'd0, md_valid}, 32'd0);
    run_div("divu_post_rst", OP_DIVU, 32'd9, 32'd3, 5'd2, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
